// File: rtl/ik_jjt_bias_engine_if.sv
// Handshake and matrix bus between the IK pipeline and the J*J^T + bias*I engine.
// The master drives the Jacobian and control; the slave (the engine) returns the result.
interface ik_jjt_bias_engine_if #(
   parameter int TASK_DIM   = 6,
   parameter int NUM_JOINTS = 6,
   parameter int W          = 27
);
   logic                en;
   logic                start;
   logic signed [W-1:0] bias;
   logic signed [W-1:0] jacobian [TASK_DIM][NUM_JOINTS];
   logic                busy;
   logic                done;
   logic                valid;
   logic signed [W-1:0] jjt_bias [TASK_DIM][TASK_DIM];

   modport master (
      output en, start, bias, jacobian,
      input  busy, done, valid, jjt_bias
   );

   modport slave (
      input  en, start, bias, jacobian,
      output busy, done, valid, jjt_bias
   );
endinterface

// File: rtl/ik_jjt_bias_engine.sv
// Sequential damped-least-squares term A = J*J^T + bias*I using one signed MAC per cycle.
// Only the upper triangle is computed; each element is mirrored into the lower triangle.
module ik_jjt_bias_engine #(
   parameter int TASK_DIM   = 6,
   parameter int NUM_JOINTS = 6,
   parameter int W          = 27,
   parameter int FRAC       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ik_jjt_bias_engine_if.slave   bus
);

   localparam int IW    = (TASK_DIM > 1) ? $clog2(TASK_DIM) : 1;
   localparam int KW    = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1;
   localparam int ACC_W = 2*W + $clog2(NUM_JOINTS) + 2;

   localparam logic [IW-1:0] I_LAST = IW'(TASK_DIM - 1);
   localparam logic [KW-1:0] K_LAST = KW'(NUM_JOINTS - 1);

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic signed [W-1:0]     r_jac    [TASK_DIM][NUM_JOINTS];
   logic signed [W-1:0]     r_result [TASK_DIM][TASK_DIM];
   logic signed [W-1:0]     r_bias;
   logic signed [ACC_W-1:0] r_acc;
   logic [IW-1:0]           r_i;
   logic [IW-1:0]           r_j;
   logic [KW-1:0]           r_k;
   logic                    r_valid;

   logic signed [W-1:0]     w_a;
   logic signed [W-1:0]     w_b;
   logic signed [2*W-1:0]   w_prod;
   logic signed [ACC_W-1:0] w_prod_ext;
   logic signed [ACC_W-1:0] w_bias_term;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_shift;
   logic signed [W-1:0]     w_elem;
   logic                    w_elem_last;
   logic                    w_row_last;
   logic                    w_final;
   logic                    w_busy;
   logic                    w_done;

   // ---------------------------------------------------------------- datapath
   assign w_a         = r_jac[r_i][r_k];
   assign w_b         = r_jac[r_j][r_k];
   assign w_prod      = w_a * w_b;
   assign w_prod_ext  = {{(ACC_W-2*W){w_prod[2*W-1]}}, w_prod};
   assign w_bias_term = (r_i == r_j) ? {{(ACC_W-W-FRAC){r_bias[W-1]}}, r_bias, {FRAC{1'b0}}}
                                     : '0;
   assign w_sum       = r_acc + w_prod_ext + w_bias_term;
   assign w_shift     = w_sum >>> FRAC;

   always_comb begin
      w_elem = w_shift[W-1:0];
      if (w_shift > SAT_MAX) begin
         w_elem = SAT_MAX[W-1:0];
      end else if (w_shift < SAT_MIN) begin
         w_elem = SAT_MIN[W-1:0];
      end
   end

   assign w_elem_last = (r_k == K_LAST);
   assign w_row_last  = (r_j == I_LAST);
   assign w_final     = w_elem_last && w_row_last && (r_i == I_LAST);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (bus.en) begin
         case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_MAC;
            S_MAC:   if (w_final)   w_state_next = S_DONE;
            S_DONE:                 w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_MAC:   w_busy = 1'b1;
         S_DONE:  w_done = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- sequencing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bias  <= '0;
         r_acc   <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_valid <= 1'b0;
         for (int a = 0; a < TASK_DIM; a++) begin
            for (int b = 0; b < NUM_JOINTS; b++) r_jac[a][b] <= '0;
            for (int b = 0; b < TASK_DIM; b++)   r_result[a][b] <= '0;
         end
      end else if (bus.en) begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_jac   <= bus.jacobian;
                  r_bias  <= bus.bias;
                  r_acc   <= '0;
                  r_i     <= '0;
                  r_j     <= '0;
                  r_k     <= '0;
                  r_valid <= 1'b0;
               end
            end
            S_MAC: begin
               if (w_elem_last) begin
                  r_result[r_i][r_j] <= w_elem;
                  r_result[r_j][r_i] <= w_elem;
                  r_acc <= '0;
                  r_k   <= '0;
                  // Park the indices at zero after the last element so no read goes out of range.
                  if (w_final) begin
                     r_i     <= '0;
                     r_j     <= '0;
                     r_valid <= 1'b1;
                  end else if (w_row_last) begin
                     r_i <= r_i + 1'b1;
                     r_j <= r_i + 1'b1;
                  end else begin
                     r_j <= r_j + 1'b1;
                  end
               end else begin
                  r_acc <= r_acc + w_prod_ext;
                  r_k   <= r_k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.busy  = w_busy;
   assign bus.done  = w_done;
   assign bus.valid = r_valid;

   generate
      for (genvar gi = 0; gi < TASK_DIM; gi++) begin : g_row
         for (genvar gj = 0; gj < TASK_DIM; gj++) begin : g_col
            assign bus.jjt_bias[gi][gj] = r_result[gi][gj];
         end
      end
   endgenerate

endmodule

// File: tb/tb_ik_jjt_bias_engine.sv
// Directed bench for ik_jjt_bias_engine: default 6x6 instance plus a 3x7 instance,
// checking latency, saturation, stalls, reset mid-run and start filtering.
module tb_ik_jjt_bias_engine;

   localparam int W = 27;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ik_jjt_bias_engine_if #(.TASK_DIM(6), .NUM_JOINTS(6), .W(W)) if0 ();
   ik_jjt_bias_engine_if #(.TASK_DIM(3), .NUM_JOINTS(7), .W(W)) if1 ();

   ik_jjt_bias_engine #(.TASK_DIM(6), .NUM_JOINTS(6), .W(W), .FRAC(16)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.slave)
   );

   ik_jjt_bias_engine #(.TASK_DIM(3), .NUM_JOINTS(7), .W(W), .FRAC(16)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   int     checks = 0;
   int     errors = 0;
   longint jm   [6][7];
   longint bv;
   longint expm [6][6];

   // Reference: full-precision sum in longint, then shift and clamp.
   task automatic model(input int t, input int nj);
      longint s;
      longint r;
      for (int i = 0; i < t; i++) begin
         for (int j = 0; j < t; j++) begin
            s = 0;
            for (int k = 0; k < nj; k++) s += jm[i][k] * jm[j][k];
            if (i == j) s += bv * 65536;
            r = s >>> 16;
            if (r > 67108863)  r = 67108863;
            if (r < -67108864) r = -67108864;
            expm[i][j] = r;
         end
      end
   endtask

   task automatic clear_jm();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++) jm[r][c] = 0;
      bv = 0;
   endtask

   task automatic load0();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) if0.jacobian[r][c] = W'(jm[r][c]);
      if0.bias = W'(bv);
   endtask

   task automatic load1();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 7; c++) if1.jacobian[r][c] = W'(jm[r][c]);
      if1.bias = W'(bv);
   endtask

   // Start the 6x6 engine and count cycles from busy rising to done; optional 10-cycle en stall.
   task automatic run0(input int stall_at, output int cycles);
      @(negedge clk);
      if0.start = 1'b1;
      @(negedge clk);
      if0.start = 1'b0;
      checks++;
      if (if0.busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_rise: got %b expected 1", if0.busy);
      end
      cycles = 0;
      while (if0.done !== 1'b1 && cycles < 2000) begin
         if (cycles == stall_at)      if0.en = 1'b0;
         if (cycles == stall_at + 10) if0.en = 1'b1;
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      if0.en = 1'b0; if0.start = 1'b0;
      if1.en = 1'b0; if1.start = 1'b0;
      clear_jm();
      load0();
      load1();
      #12;
      checks++;
      if ({if0.busy, if0.done, if0.valid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags0: got %b expected 000", {if0.busy, if0.done, if0.valid});
      end
      checks++;
      if ({if1.busy, if1.done, if1.valid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags1: got %b expected 000", {if1.busy, if1.done, if1.valid});
      end
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            checks++;
            if (if0.jjt_bias[i][j] !== 27'd0) begin
               errors++;
               $display("FAIL reset_elem[%0d][%0d]: got %0d expected 0", i, j, longint'(if0.jjt_bias[i][j]));
            end
         end
      @(negedge clk);
      rst_n = 1'b1;
      if0.en = 1'b1;
      if1.en = 1'b1;
      $display("test_reset: outputs cleared under reset");
   endtask

   task automatic test_identity();
      int cyc;
      longint e;
      clear_jm();
      for (int d = 0; d < 6; d++) jm[d][d] = 65536;
      load0();
      run0(-1, cyc);
      checks++;
      if (cyc !== 126) begin
         errors++;
         $display("FAIL identity_latency: got %0d expected 126", cyc);
      end
      checks++;
      if (if0.valid !== 1'b1) begin
         errors++;
         $display("FAIL identity_valid: got %b expected 1", if0.valid);
      end
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            e = (i == j) ? 65536 : 0;
            checks++;
            if (longint'(if0.jjt_bias[i][j]) !== e) begin
               errors++;
               $display("FAIL identity_elem[%0d][%0d]: got %0d expected %0d", i, j, longint'(if0.jjt_bias[i][j]), e);
            end
         end
      @(negedge clk);
      checks++;
      if ({if0.busy, if0.done, if0.valid} !== 3'b001) begin
         errors++;
         $display("FAIL identity_after_done: got %b expected 001", {if0.busy, if0.done, if0.valid});
      end
      $display("test_identity: latency=%0d", cyc);
   endtask

   task automatic test_all_ones();
      int cyc;
      longint e;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) jm[r][c] = 65536;
      bv = 32768;
      load0();
      run0(-1, cyc);
      checks++;
      if (cyc !== 126) begin
         errors++;
         $display("FAIL ones_latency: got %0d expected 126", cyc);
      end
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            e = (i == j) ? 425984 : 393216;
            checks++;
            if (longint'(if0.jjt_bias[i][j]) !== e) begin
               errors++;
               $display("FAIL ones_elem[%0d][%0d]: got %0d expected %0d", i, j, longint'(if0.jjt_bias[i][j]), e);
            end
         end
      // DONE must hold while en is low.
      if0.en = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({if0.busy, if0.done} !== 2'b01) begin
         errors++;
         $display("FAIL ones_done_hold: got %b expected 01", {if0.busy, if0.done});
      end
      if0.en = 1'b1;
      @(negedge clk);
      checks++;
      if ({if0.busy, if0.done, if0.valid} !== 3'b001) begin
         errors++;
         $display("FAIL ones_release: got %b expected 001", {if0.busy, if0.done, if0.valid});
      end
      $display("test_all_ones: latency=%0d", cyc);
   endtask

   task automatic test_saturation();
      int cyc;
      clear_jm();
      for (int c = 0; c < 6; c++) begin
         jm[0][c] = 67108863;
         jm[1][c] = -67108863;
      end
      load0();
      run0(-1, cyc);
      checks++;
      if (longint'(if0.jjt_bias[0][0]) !== 64'sd67108863) begin
         errors++;
         $display("FAIL sat_00: got %0d expected 67108863", longint'(if0.jjt_bias[0][0]));
      end
      checks++;
      if (longint'(if0.jjt_bias[0][1]) !== -64'sd67108864) begin
         errors++;
         $display("FAIL sat_01: got %0d expected -67108864", longint'(if0.jjt_bias[0][1]));
      end
      checks++;
      if (longint'(if0.jjt_bias[1][0]) !== -64'sd67108864) begin
         errors++;
         $display("FAIL sat_10: got %0d expected -67108864", longint'(if0.jjt_bias[1][0]));
      end
      checks++;
      if (longint'(if0.jjt_bias[1][1]) !== 64'sd67108863) begin
         errors++;
         $display("FAIL sat_11: got %0d expected 67108863", longint'(if0.jjt_bias[1][1]));
      end
      checks++;
      if (longint'(if0.jjt_bias[0][2]) !== 64'sd0) begin
         errors++;
         $display("FAIL sat_02: got %0d expected 0", longint'(if0.jjt_bias[0][2]));
      end
      $display("test_saturation: latency=%0d", cyc);
   endtask

   task automatic test_random_stall();
      int cyc;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) jm[r][c] = longint'($signed($urandom) >>> 11);
      bv = longint'($signed($urandom) >>> 12);
      model(6, 6);
      load0();
      run0(40, cyc);
      checks++;
      if (cyc !== 136) begin
         errors++;
         $display("FAIL stall_latency: got %0d expected 136", cyc);
      end
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            checks++;
            if (longint'(if0.jjt_bias[i][j]) !== expm[i][j]) begin
               errors++;
               $display("FAIL stall_elem[%0d][%0d]: got %0d expected %0d", i, j, longint'(if0.jjt_bias[i][j]), expm[i][j]);
            end
         end
      $display("test_random_stall: latency=%0d", cyc);
   endtask

   task automatic test_reset_midrun();
      int cyc;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) jm[r][c] = longint'($signed($urandom) >>> 11);
      bv = longint'($signed($urandom) >>> 12);
      load0();
      @(negedge clk);
      if0.start = 1'b1;
      @(negedge clk);
      if0.start = 1'b0;
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({if0.busy, if0.done, if0.valid} !== 3'b000) begin
         errors++;
         $display("FAIL midrst_flags: got %b expected 000", {if0.busy, if0.done, if0.valid});
      end
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            checks++;
            if (if0.jjt_bias[i][j] !== 27'd0) begin
               errors++;
               $display("FAIL midrst_elem[%0d][%0d]: got %0d expected 0", i, j, longint'(if0.jjt_bias[i][j]));
            end
         end
      @(negedge clk);
      rst_n = 1'b1;
      model(6, 6);
      run0(-1, cyc);
      checks++;
      if (cyc !== 126) begin
         errors++;
         $display("FAIL midrst_latency: got %0d expected 126", cyc);
      end
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            checks++;
            if (longint'(if0.jjt_bias[i][j]) !== expm[i][j]) begin
               errors++;
               $display("FAIL midrst_elem_rerun[%0d][%0d]: got %0d expected %0d", i, j, longint'(if0.jjt_bias[i][j]), expm[i][j]);
            end
         end
      $display("test_reset_midrun: rerun latency=%0d", cyc);
   endtask

   task automatic test_start_ignored();
      int cyc;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) jm[r][c] = 65536;
      bv = 0;
      load0();
      @(negedge clk);
      if0.start = 1'b1;
      @(negedge clk);
      if0.start = 1'b0;
      cyc = 0;
      while (if0.done !== 1'b1 && cyc < 2000) begin
         if (cyc == 30) begin
            clear_jm();
            for (int d = 0; d < 6; d++) jm[d][d] = 65536;
            load0();
            if0.start = 1'b1;
         end
         if (cyc == 31) if0.start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== 126) begin
         errors++;
         $display("FAIL ign_latency: got %0d expected 126", cyc);
      end
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            checks++;
            if (longint'(if0.jjt_bias[i][j]) !== 64'sd393216) begin
               errors++;
               $display("FAIL ign_elem[%0d][%0d]: got %0d expected 393216", i, j, longint'(if0.jjt_bias[i][j]));
            end
         end
      // start raised in DONE is dropped; held one more cycle it is accepted from IDLE.
      if0.start = 1'b1;
      @(negedge clk);
      checks++;
      if ({if0.busy, if0.done, if0.valid} !== 3'b001) begin
         errors++;
         $display("FAIL ign_done_start: got %b expected 001", {if0.busy, if0.done, if0.valid});
      end
      @(negedge clk);
      if0.start = 1'b0;
      checks++;
      if ({if0.busy, if0.valid} !== 2'b10) begin
         errors++;
         $display("FAIL ign_new_accept: got %b expected 10", {if0.busy, if0.valid});
      end
      cyc = 0;
      while (if0.done !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== 126) begin
         errors++;
         $display("FAIL ign_new_latency: got %0d expected 126", cyc);
      end
      checks++;
      if (longint'(if0.jjt_bias[0][0]) !== 64'sd65536 || longint'(if0.jjt_bias[0][1]) !== 64'sd0
          || longint'(if0.jjt_bias[5][5]) !== 64'sd65536) begin
         errors++;
         $display("FAIL ign_new_result: got %0d %0d %0d expected 65536 0 65536",
                  longint'(if0.jjt_bias[0][0]), longint'(if0.jjt_bias[0][1]), longint'(if0.jjt_bias[5][5]));
      end
      $display("test_start_ignored: second run latency=%0d", cyc);
   endtask

   task automatic test_small_instance();
      int cyc;
      clear_jm();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 7; c++) jm[r][c] = longint'($signed($urandom) >>> 11);
      bv = longint'($signed($urandom) >>> 12);
      model(3, 7);
      load1();
      @(negedge clk);
      if1.start = 1'b1;
      @(negedge clk);
      if1.start = 1'b0;
      cyc = 0;
      while (if1.done !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== 42) begin
         errors++;
         $display("FAIL small_latency: got %0d expected 42", cyc);
      end
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            checks++;
            if (longint'(if1.jjt_bias[i][j]) !== expm[i][j]) begin
               errors++;
               $display("FAIL small_elem[%0d][%0d]: got %0d expected %0d", i, j, longint'(if1.jjt_bias[i][j]), expm[i][j]);
            end
         end
      $display("test_small_instance: latency=%0d", cyc);
   endtask

   initial begin
      test_reset();
      test_identity();
      test_all_ones();
      test_saturation();
      test_random_stall();
      test_reset_midrun();
      test_start_ignored();
      test_small_instance();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
